// File: rtl/levenshtein_pkg.sv
// rtl/levenshtein_pkg.sv - Wishbone cycle/burst codes, SPI SRAM opcodes and responder state type
package levenshtein_pkg;

    localparam logic [2:0] CTI_CLASSIC           = 3'b000;
    localparam logic [2:0] CTI_INCREMENTAL_BURST = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST      = 3'b111;
    localparam logic [1:0] BTE_LINEAR_BURST      = 2'b00;

    localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
    localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_ACK,
        ST_BURST,
        ST_CS_HIGH
    } sram_state_e;

    // Device select 1..3 drives chip-select line 0..2 low; 0 leaves all high.
    function automatic logic [2:0] cs_decode(input logic [1:0] cfg);
        logic [2:0] sel;
        sel = 3'b001 << (cfg - 2'd1);
        return ~sel;
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - MSB-first mode-0 SPI shift engine shared by command and data phases
module spi_shifter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] load_data,
    input  logic [5:0]  load_bits,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [7:0]  rx_byte
);

    logic [31:0] shreg;
    logic [5:0]  bits_left;
    logic        busy;

    // sck doubles as the phase flag: low = setup half, high = sample half
    assign done    = busy & sck & (bits_left == 6'd1);
    assign rx_byte = {shreg[6:0], miso};

    always_ff @(posedge clk_i) begin
        if (!rst_ni || abort) begin
            shreg     <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else if (start) begin
            shreg     <= load_data;
            bits_left <= load_bits;
            busy      <= 1'b1;
            sck       <= 1'b0;
            mosi      <= load_data[31];
        end else if (busy) begin
            if (!sck) begin
                sck <= 1'b1;
            end else begin
                shreg     <= {shreg[30:0], miso};
                bits_left <= bits_left - 6'd1;
                sck       <= 1'b0;
                if (bits_left == 6'd1) begin
                    busy <= 1'b0;
                    mosi <= 1'b0;
                end else begin
                    mosi <= shreg[30];
                end
            end
        end
    end

endmodule

// File: rtl/spi_sram_responder.sv
// rtl/spi_sram_responder.sv - Wishbone B4 byte slave backed by a 23LC-class SPI SRAM
// Define SPI_SRAM_BURST_EN to keep CS low across linear incremental bursts.
module spi_sram_responder #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [7:0]            wbs_dat_i,
    input  logic [2:0]            wbs_cti_i,
    input  logic [1:0]            wbs_bte_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic                  wbs_rty_o,
    output logic [7:0]            wbs_dat_o,
    input  logic [1:0]            sram_config_i,
    output logic                  spi_sck_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    output logic [2:0]            spi_cs_n_o
);
    import levenshtein_pkg::*;

    sram_state_e state;
    logic        we_q;
    logic [23:0] adr_q;
    logic [7:0]  dat_q;
    logic        req;
    logic        sh_start;
    logic        sh_abort;
    logic        sh_done;
    logic [31:0] sh_data;
    logic [5:0]  sh_bits;
    logic [7:0]  rx_byte;

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign wbs_rty_o = 1'b0;

`ifdef SPI_SRAM_BURST_EN
    logic burst_q;
    logic burst_beat;
    logic beat_continues;

    assign burst_beat     = (wbs_cti_i == CTI_INCREMENTAL_BURST) && (wbs_bte_i == BTE_LINEAR_BURST);
    // The SRAM auto-increments, so only an exact +1 (mod 2^24) beat may skip the command.
    assign beat_continues = req
                          && (wbs_cti_i == CTI_INCREMENTAL_BURST || wbs_cti_i == CTI_END_OF_BURST)
                          && (wbs_we_i == we_q)
                          && (wbs_adr_i[23:0] == adr_q + 24'd1);
`else
    logic unused_burst_inputs;
    assign unused_burst_inputs = ^{wbs_cti_i, wbs_bte_i};
`endif

    always_comb begin
        sh_start = 1'b0;
        sh_data  = 32'h0;
        sh_bits  = 6'd8;
        case (state)
            ST_IDLE: if (req && sram_config_i != 2'd0) begin
                sh_start = 1'b1;
                sh_bits  = 6'd32;
                sh_data  = {wbs_we_i ? SRAM_CMD_WRITE : SRAM_CMD_READ, wbs_adr_i[23:0]};
            end
            ST_CMD: if (wbs_cyc_i && sh_done) begin
                sh_start = 1'b1;
                sh_data  = {we_q ? dat_q : 8'h00, 24'h0};
            end
`ifdef SPI_SRAM_BURST_EN
            ST_BURST: if (beat_continues) begin
                sh_start = 1'b1;
                sh_data  = {wbs_we_i ? wbs_dat_i : 8'h00, 24'h0};
            end
`endif
            default: ;
        endcase
    end

    assign sh_abort = (state == ST_CMD || state == ST_DATA) && !wbs_cyc_i;

    spi_shifter u_shifter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start     (sh_start),
        .abort     (sh_abort),
        .load_data (sh_data),
        .load_bits (sh_bits),
        .miso      (spi_miso_i),
        .sck       (spi_sck_o),
        .mosi      (spi_mosi_o),
        .done      (sh_done),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            adr_q      <= 24'h0;
            dat_q      <= 8'h00;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_dat_o  <= 8'h00;
            spi_cs_n_o <= 3'b111;
`ifdef SPI_SRAM_BURST_EN
            burst_q    <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                ST_IDLE: if (req) begin
                    if (sram_config_i == 2'd0) begin
                        wbs_err_o <= 1'b1;
                        state     <= ST_ACK;
`ifdef SPI_SRAM_BURST_EN
                        burst_q   <= 1'b0;
`endif
                    end else begin
                        we_q       <= wbs_we_i;
                        adr_q      <= wbs_adr_i[23:0];
                        dat_q      <= wbs_dat_i;
                        spi_cs_n_o <= cs_decode(sram_config_i);
                        state      <= ST_CMD;
`ifdef SPI_SRAM_BURST_EN
                        burst_q    <= burst_beat;
`endif
                    end
                end
                ST_CMD: begin
                    if (!wbs_cyc_i) begin
                        spi_cs_n_o <= 3'b111;
                        state      <= ST_CS_HIGH;
                    end else if (sh_done) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!wbs_cyc_i) begin
                        spi_cs_n_o <= 3'b111;
                        state      <= ST_CS_HIGH;
                    end else if (sh_done) begin
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= we_q ? 8'h00 : rx_byte;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
`ifdef SPI_SRAM_BURST_EN
                    if (burst_q) begin
                        state <= ST_BURST;
                    end else begin
                        spi_cs_n_o <= 3'b111;
                        state      <= ST_CS_HIGH;
                    end
`else
                    spi_cs_n_o <= 3'b111;
                    state      <= ST_CS_HIGH;
`endif
                end
`ifdef SPI_SRAM_BURST_EN
                ST_BURST: begin
                    if (!wbs_cyc_i) begin
                        spi_cs_n_o <= 3'b111;
                        state      <= ST_CS_HIGH;
                    end else if (beat_continues) begin
                        we_q    <= wbs_we_i;
                        adr_q   <= wbs_adr_i[23:0];
                        dat_q   <= wbs_dat_i;
                        burst_q <= burst_beat;
                        state   <= ST_DATA;
                    end else if (req) begin
                        spi_cs_n_o <= 3'b111;
                        state      <= ST_CS_HIGH;
                    end
                end
`endif
                ST_CS_HIGH: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// tb/tb_spi_sram_responder.sv - scoreboard bench for spi_sram_responder against an SPI SRAM model
module tb_spi_sram_responder;
    import levenshtein_pkg::*;

`ifdef SPI_SRAM_BURST_EN
    localparam int unsigned NEXT_LAT = 18;
    localparam int          BURST_ON = 1;
`else
    localparam int unsigned NEXT_LAT = 83;
    localparam int          BURST_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [23:0] wbs_adr_i;
    logic [7:0]  wbs_dat_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [7:0]  wbs_dat_o;
    logic [1:0]  sram_config_i;
    logic        spi_sck_o, spi_mosi_o;
    logic        spi_miso_i = 1'b0;
    logic [2:0]  spi_cs_n_o;

    spi_sram_responder dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o),
        .sram_config_i(sram_config_i),
        .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i), .spi_cs_n_o(spi_cs_n_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // SPI SRAM model: 32 command bits, then auto-incrementing data bytes
    logic [7:0]  mem [logic [23:0]];
    int          sck_cnt = 0;
    logic [31:0] cmd_sr = 32'h0;
    logic [31:0] last_cmd = 32'h0;
    logic [2:0]  last_cs = 3'b111;
    logic [23:0] cur_adr = 24'h0;
    logic        cur_write = 1'b0;
    logic [7:0]  wr_sr = 8'h0;
    logic [7:0]  rb;
    int          cmd_count = 0;
    int          cs_rise = 0;
    int          cs_fall = 0;
    logic        sck_prev = 1'b0;
    logic [2:0]  cs_prev = 3'b111;

    function automatic logic [7:0] sram_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(spi_sck_o or spi_cs_n_o) begin
        if (spi_cs_n_o != cs_prev) begin
            if (spi_cs_n_o == 3'b111) begin
                cs_rise++;
                sck_cnt = 0;
                spi_miso_i = 1'b0;
            end else if (cs_prev == 3'b111) begin
                cs_fall++;
            end
        end
        if (spi_cs_n_o != 3'b111 && spi_sck_o && !sck_prev) begin
            if (sck_cnt < 32) begin
                cmd_sr = {cmd_sr[30:0], spi_mosi_o};
                if (sck_cnt == 31) begin
                    last_cmd  = cmd_sr;
                    last_cs   = spi_cs_n_o;
                    cmd_count++;
                    cur_adr   = cmd_sr[23:0];
                    cur_write = (cmd_sr[31:24] == 8'h02);
                end
            end else begin
                wr_sr = {wr_sr[6:0], spi_mosi_o};
                if (((sck_cnt - 32) % 8) == 7) begin
                    if (cur_write) mem[cur_adr] = wr_sr;
                    cur_adr = cur_adr + 24'd1;
                end
            end
            sck_cnt++;
        end
        if (spi_cs_n_o != 3'b111 && !spi_sck_o && sck_prev && sck_cnt >= 32) begin
            rb = sram_rd(cur_adr);
            spi_miso_i = rb[3'(7 - ((sck_cnt - 32) % 8))];
        end
        sck_prev = spi_sck_o;
        cs_prev  = spi_cs_n_o;
    end

    // Scoreboard: stimulus pushes, monitor pops on every ack/err
    typedef struct {
        logic        is_err;
        logic [7:0]  dat;
        int unsigned at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1 || wbs_err_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'({wbs_ack_o, wbs_err_o}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_ack", 32'(wbs_ack_o), 32'(!mon_e.is_err));
                check("resp_err", 32'(wbs_err_o), 32'(mon_e.is_err));
                if (!mon_e.is_err) check("resp_dat", 32'(wbs_dat_o), 32'(mon_e.dat));
                check("resp_cycle", cyc_cnt, mon_e.at);
            end
        end
    end

    task automatic beat(input logic we, input logic [23:0] adr, input logic [7:0] wd,
                        input logic [2:0] cti, input int unsigned lat,
                        input logic exp_err, input logic [7:0] exp_dat);
        int n;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wd;   wbs_cti_i = cti; wbs_bte_i = BTE_LINEAR_BURST;
        exp_q.push_back('{exp_err, exp_dat, cyc_cnt + lat});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wbs_ack_o || wbs_err_o) && n < 200);
        if (!(wbs_ack_o || wbs_err_o)) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cti_i = CTI_CLASSIC;
        repeat (n) @(negedge clk);
    endtask

    int c0, r0, f0;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        mem[24'h000200] = 8'h5A;
        mem[24'h000400] = 8'h11;
        mem[24'h000401] = 8'h22;
        mem[24'h000402] = 8'h33;
        mem[24'hFFFFFF] = 8'hE1;
        mem[24'h000000] = 8'h0E;
        rst_ni = 1'b0; sram_config_i = 2'd0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = 24'h0; wbs_dat_i = 8'h0; wbs_cti_i = CTI_CLASSIC; wbs_bte_i = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_err", 32'(wbs_err_o), 32'd0);
        check("rst_rty", 32'(wbs_rty_o), 32'd0);
        check("rst_dat", 32'(wbs_dat_o), 32'h00);
        check("rst_sck", 32'(spi_sck_o), 32'd0);
        check("rst_mosi", 32'(spi_mosi_o), 32'd0);
        check("rst_cs", 32'(spi_cs_n_o), 32'h7);
        rst_ni = 1'b1;
        idle(2);

        // classic read, device 1
        sram_config_i = 2'd1; c0 = cmd_count;
        beat(1'b0, 24'h000200, 8'h00, CTI_CLASSIC, 81, 1'b0, 8'h5A);
        idle(4);
        check("rd_cmd", last_cmd, 32'h03000200);
        check("rd_cs", 32'(last_cs), 32'h6);
        check("rd_ncmd", 32'(cmd_count - c0), 32'd1);

        // classic write, device 2
        sram_config_i = 2'd2;
        beat(1'b1, 24'h000010, 8'hC3, CTI_CLASSIC, 81, 1'b0, 8'h00);
        idle(4);
        check("wr_cmd", last_cmd, 32'h02000010);
        check("wr_cs", 32'(last_cs), 32'h5);
        check("wr_mem", 32'(sram_rd(24'h000010)), 32'hC3);

        // incremental read burst of three
        sram_config_i = 2'd1; c0 = cmd_count; r0 = cs_rise;
        beat(1'b0, 24'h000400, 8'h00, CTI_INCREMENTAL_BURST, 81, 1'b0, 8'h11);
        beat(1'b0, 24'h000401, 8'h00, CTI_INCREMENTAL_BURST, NEXT_LAT, 1'b0, 8'h22);
        beat(1'b0, 24'h000402, 8'h00, CTI_END_OF_BURST, NEXT_LAT, 1'b0, 8'h33);
        idle(4);
        check("burst_ncmd", 32'(cmd_count - c0), BURST_ON ? 32'd1 : 32'd3);
        check("burst_cs_rise", 32'(cs_rise - r0), BURST_ON ? 32'd1 : 32'd3);

        // no device selected
        sram_config_i = 2'd0; f0 = cs_fall;
        beat(1'b0, 24'h000200, 8'h00, CTI_CLASSIC, 1, 1'b1, 8'h00);
        idle(4);
        check("err_cs_fall", 32'(cs_fall - f0), 32'd0);

        // abort: cyc dropped so that the DUT sees it at edge n+30
        sram_config_i = 2'd1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 24'h000200; wbs_cti_i = CTI_CLASSIC;
        repeat (30) @(negedge clk);
        check("abort_cs_before", 32'(spi_cs_n_o), 32'h6);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        check("abort_cs_after", 32'(spi_cs_n_o), 32'h7);
        idle(100);
        c0 = cmd_count;
        beat(1'b0, 24'h000200, 8'h00, CTI_CLASSIC, 81, 1'b0, 8'h5A);
        idle(4);
        check("abort_ncmd", 32'(cmd_count - c0), 32'd1);
        check("abort_cmd", last_cmd, 32'h03000200);

        // reset asserted so that the DUT samples it at edge n+70
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 24'h000401; wbs_cti_i = CTI_CLASSIC;
        repeat (70) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", 32'(wbs_ack_o), 32'd0);
        check("mid_rst_dat", 32'(wbs_dat_o), 32'h00);
        check("mid_rst_sck", 32'(spi_sck_o), 32'd0);
        check("mid_rst_mosi", 32'(spi_mosi_o), 32'd0);
        check("mid_rst_cs", 32'(spi_cs_n_o), 32'h7);
        rst_ni = 1'b1;
        idle(100);
        beat(1'b0, 24'h000402, 8'h00, CTI_CLASSIC, 81, 1'b0, 8'h33);
        idle(4);

        // burst across the 24-bit address wrap
        c0 = cmd_count;
        beat(1'b0, 24'hFFFFFF, 8'h00, CTI_INCREMENTAL_BURST, 81, 1'b0, 8'hE1);
        beat(1'b0, 24'h000000, 8'h00, CTI_END_OF_BURST, NEXT_LAT, 1'b0, 8'h0E);
        idle(4);
        check("wrap_ncmd", 32'(cmd_count - c0), BURST_ON ? 32'd1 : 32'd2);
        check("wrap_cs", 32'(spi_cs_n_o), 32'h7);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sram_responder.md
# spi_sram_responder

Wishbone B4 slave that serves the byte-wide dictionary and bit-vector reads issued by the Levenshtein engine's Wishbone master, and the host's loading writes, from an external SPI SRAM (23LC-class, 24-bit address). The block translates each Wishbone access into SPI READ (0x03) or WRITE (0x02) transactions. With burst support compiled in, it keeps chip select asserted across incremental bursts so each burst beat costs only one data byte on the SPI bus. `sram_config_i` is driven from the controller's `sram_config` register.

## Interface
- `ADDR_WIDTH`, default 24: Wishbone address width. The low 24 bits go out on SPI.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset. Synchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone cycle, strobe and write enable.
- `wbs_adr_i` in ADDR_WIDTH: byte address.
- `wbs_dat_i` in 8: write data.
- `wbs_cti_i` in 3: cycle type. 000 = classic, 010 = incremental burst, 111 = end of burst.
- `wbs_bte_i` in 2: burst type. Only 00 (linear) is burst-eligible.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_err_o` out 1: one-cycle error.
- `wbs_rty_o` out 1: tied 0.
- `wbs_dat_o` out 8: read data. Valid while `wbs_ack_o`=1.
- `sram_config_i` in 2: device select. 0 = none; 1..3 select chip-select line 0..2.
- `spi_sck_o` out 1: SPI clock, mode 0, clk_i/2.
- `spi_mosi_o` out 1: SPI data out, MSB first.
- `spi_miso_i` in 1: SPI data in.
- `spi_cs_n_o` out 3: active-low chip selects, one-hot low.

## Operation
- States:
  - IDLE: waits for a Wishbone request.
  - CMD: shifts out 32 bits, {cmd, adr[23:0]}.
  - DATA: shifts 8 bits.
  - ACK: drives ack/err for one cycle.
  - BURST: holds CS low, waits for the next beat.
  - CS_HIGH: one cycle with CS deasserted.
- IDLE, request present (`cyc&stb`):
  - `sram_config_i`==0: go to ACK with `wbs_err_o`=1.
  - Otherwise: latch `sram_config_i`, we, address and write data. Drive the selected `spi_cs_n_o` bit low. Go to CMD.
- SPI bit timing:
  - Each bit takes 2 cycles. Cycle A: sck=0, MOSI updated. Cycle B: sck=1, MISO sampled.
  - Reads shift MISO into `wbs_dat_o`.
  - MOSI is 0 during read data bits.
- DATA done → ACK: `wbs_ack_o`=1 for exactly one cycle. `wbs_dat_o` holds the read byte, or 00 on writes.
- After ACK:
  - Go to BURST if the beat's cti was 010 and bte was 00.
  - Otherwise go to CS_HIGH, then IDLE.
- BURST:
  - Request present with cti ∈ {010, 111}, the same we, and adr == previous adr+1: latch it and go straight to DATA. The SRAM auto-increments, so no command is re-sent.
  - Request that does not continue the burst (different cti, we, or address): go to CS_HIGH, then IDLE, which starts a new command for it.
  - `cyc` dropped: go to CS_HIGH.
- Abort: if `cyc` falls during CMD or DATA, raise CS the next cycle and go to CS_HIGH without ack. A later transaction starts with a fresh command.
- Address arithmetic wraps at 24 bits: 0xFFFFFF+1 = 0x000000 counts as contiguous.
- Reset values: `wbs_ack_o`=0, `wbs_err_o`=0, `wbs_dat_o`=00, `spi_sck_o`=0, `spi_mosi_o`=0, `spi_cs_n_o`=111. State is IDLE.
- Reset mid-transaction: all outputs return to reset values on the next edge; no ack is issued.

## Timing
- Reference point: request sampled at edge n in IDLE.
- Classic read or write:
  - CS goes low in cycle n+1.
  - CMD occupies n+1..n+64.
  - DATA occupies n+65..n+80.
  - ack is high in cycle n+81.
- Continuing burst beat, sampled at edge m in BURST:
  - DATA occupies m+1..m+16.
  - ack is high in m+17.
- Error response (`sram_config_i`==0): err is high in cycle n+1.
- Minimum CS high time: 1 cycle (CS_HIGH).
- `stb` must stay high until ack. Changes to adr, we or data after latch are ignored.

## Configuration
- `SPI_SRAM_BURST_EN` defined: BURST state and the CS-held continuation path exist, as described above.
- `SPI_SRAM_BURST_EN` undefined:
  - Every beat is a full command: CMD + DATA, then CS_HIGH, regardless of cti.
  - Ack latency is always 81 cycles.
  - BURST logic is removed.

## Structure
- Shared package `levenshtein_pkg` holds:
  - CTI_CLASSIC / CTI_INCREMENTAL_BURST / CTI_END_OF_BURST and BTE_LINEAR_BURST constants.
  - SPI opcodes SRAM_CMD_READ=8'h03 and SRAM_CMD_WRITE=8'h02.
  - The state enum typedef.
- One sub-module, `spi_shifter`: 32-bit MSB-first shift register with a sck phase toggle, bit counter, load/start inputs and done pulse, used for both CMD and DATA.

## Test plan
- Single classic read: config=1, adr 0x000200, SRAM byte 0x5A → `spi_cs_n_o`=110, MOSI carries 0x03000200, ack at n+81 with `wbs_dat_o`=5A.
- Classic write: config=2, adr 0x000010, dat 0xC3 → `spi_cs_n_o`=101, MOSI carries 0x02000010 then C3, ack at n+81.
- Incremental read burst of 3 at 0x000400 (cti 010, 010, 111):
  - CS stays low throughout, with a single command.
  - Acks at +81, +17, +17, returning the SRAM bytes in order.
  - CS rises after the third ack.
  - Without `SPI_SRAM_BURST_EN`: three commands, three 81-cycle acks.
- config=0 read → err=1 for one cycle at n+1, ack stays 0, CS stays 111.
- Abort and reset: `cyc` dropped at n+30 → CS 111 by n+31, no ack, next read issues a full command. `rst_ni` low at n+70 → all outputs at reset values next cycle, no ack.
- Burst address wrap: burst at 0xFFFFFF then 0x000000 → treated as contiguous, no new command.
